// File: rtl/bingo_pkg.sv
// Shared constants, FSM state type, line masks and BCD helper for the bingo board.
package bingo_pkg;

   localparam int unsigned N     = 5;
   localparam int unsigned CELLS = 25;
   localparam int unsigned NUM_W = 5;
   localparam int unsigned LINES = 12;

   typedef enum logic [2:0] {StIdle, StFill, StShuffle, StPlay, StScan} state_e;

   // Scan order: rows 0-4, columns 0-4, main diagonal, anti-diagonal.
   localparam logic [CELLS-1:0] LINE_MASK [0:LINES-1] = '{
      25'h000001F, 25'h00003E0, 25'h0007C00, 25'h00F8000, 25'h1F00000,
      25'h0108421, 25'h0210842, 25'h0421084, 25'h0842108, 25'h1084210,
      25'h1041041, 25'h0111110
   };

   function automatic logic [7:0] to_bcd(input logic [3:0] n);
      if (n >= 4'd10) begin
         return {4'd1, n - 4'd10};
      end
      return {4'd0, n};
   endfunction

endpackage

// File: rtl/bingo_board_if.sv
// Handshake and display-facing signals of the bingo board.
interface bingo_board_if;
   import bingo_pkg::*;

   logic                   start;
   logic                   mark_valid;
   logic [NUM_W-1:0]       mark_num;
   logic                   mark_ready;
   logic                   mark_done;
   logic                   mark_hit;
   logic [CELLS*NUM_W-1:0] map;
   logic [CELLS-1:0]       circle;
   logic [7:0]             display_nums;
   logic                   win;
   logic                   busy;

   modport master (
      output start, mark_valid, mark_num,
      input  mark_ready, mark_done, mark_hit, map, circle, display_nums, win, busy
   );

   modport slave (
      input  start, mark_valid, mark_num,
      output mark_ready, mark_done, mark_hit, map, circle, display_nums, win, busy
   );

endinterface

// File: rtl/bingo_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module bingo_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= SEED;
      end else begin
         value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
      end
   end

endmodule

// File: rtl/bingo_board.sv
// Bingo board game state: fill, shuffle, mark called numbers and count completed lines.
module bingo_board
   import bingo_pkg::*;
#(
   parameter bit          SHUFFLE_EN = 1'b1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned WIN_LINES  = 5
) (
   input  logic         clk,
   input  logic         rst,
   bingo_board_if.slave bus
);

   state_e             state_q;
   logic [NUM_W-1:0]   cell_q [CELLS];
   logic [4:0]         idx_q;
   logic [3:0]         line_q;
   logic [3:0]         cnt_q;
   logic [CELLS-1:0]   circle_q;
   logic [7:0]         disp_q;
   logic               win_q;
   logic               done_q;
   logic               hit_q;

   logic [15:0]        lfsr;
   logic [4:0]         rnd;
   logic               found;
   logic [4:0]         match_idx;
   logic               num_ok;
   logic               line_full;

   bingo_lfsr #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .value(lfsr)
   );

   assign rnd    = lfsr[4:0];
   assign num_ok = (bus.mark_num >= 5'd1) && (bus.mark_num <= 5'd25);

   always_comb begin
      found     = 1'b0;
      match_idx = '0;
      for (int k = 0; k < CELLS; k++) begin
         if (cell_q[k] == bus.mark_num) begin
            found     = 1'b1;
            match_idx = 5'(k);
         end
      end
   end

   // line_q == LINES is the commit cycle, not a real line.
   always_comb begin
      line_full = 1'b0;
      if (line_q < 4'(LINES)) begin
         line_full = &(circle_q | ~LINE_MASK[line_q]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         for (int k = 0; k < CELLS; k++) begin
            cell_q[k] <= '0;
         end
         idx_q    <= '0;
         line_q   <= '0;
         cnt_q    <= '0;
         circle_q <= '0;
         disp_q   <= '0;
         win_q    <= 1'b0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         hit_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StFill;
                  idx_q   <= '0;
               end
            end
            StFill: begin
               cell_q[idx_q] <= idx_q + 5'd1;
               circle_q      <= '0;
               disp_q        <= '0;
               win_q         <= 1'b0;
               if (idx_q == 5'(CELLS - 1)) begin
                  state_q <= SHUFFLE_EN ? StShuffle : StPlay;
               end else begin
                  idx_q <= idx_q + 5'd1;
               end
            end
            StShuffle: begin
               if (rnd <= idx_q) begin
                  cell_q[idx_q] <= cell_q[rnd];
                  cell_q[rnd]   <= cell_q[idx_q];
                  idx_q         <= idx_q - 5'd1;
                  if (idx_q == 5'd1) begin
                     state_q <= StPlay;
                  end
               end
            end
            StPlay: begin
               if (bus.start) begin
                  state_q <= StFill;
                  idx_q   <= '0;
               end else if (bus.mark_valid) begin
                  done_q <= 1'b1;
                  if (num_ok && found && !circle_q[match_idx]) begin
                     circle_q[match_idx] <= 1'b1;
                     hit_q   <= 1'b1;
                     state_q <= StScan;
                     line_q  <= '0;
                     cnt_q   <= '0;
                  end
               end
            end
            StScan: begin
               if (line_q == 4'(LINES)) begin
                  disp_q  <= to_bcd(cnt_q);
                  win_q   <= (32'(cnt_q) >= WIN_LINES);
                  state_q <= StPlay;
               end else begin
                  if (line_full) begin
                     cnt_q <= cnt_q + 4'd1;
                  end
                  line_q <= line_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.map = '0;
      for (int k = 0; k < CELLS; k++) begin
         bus.map[NUM_W*k +: NUM_W] = cell_q[k];
      end
   end

   assign bus.circle       = circle_q;
   assign bus.display_nums = disp_q;
   assign bus.win          = win_q;
   assign bus.mark_done    = done_q;
   assign bus.mark_hit     = hit_q;
   assign bus.mark_ready   = (state_q == StPlay);
   assign bus.busy         = (state_q == StFill) || (state_q == StShuffle) ||
                             (state_q == StScan);

endmodule

// File: tb/tb_bingo_board.sv
// Directed bench: identity board (SHUFFLE_EN=0) for marking/scan, shuffled board for permutations.
module tb_bingo_board;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bingo_board_if bus0();
   bingo_board_if bus1();

   bingo_board #(
      .SHUFFLE_EN(1'b0),
      .LFSR_SEED (16'hACE1),
      .WIN_LINES (5)
   ) u_dut0 (
      .clk(clk),
      .rst(rst),
      .bus(bus0)
   );

   bingo_board #(
      .SHUFFLE_EN(1'b1),
      .LFSR_SEED (16'hACE1),
      .WIN_LINES (5)
   ) u_dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [124:0] ident_map();
      logic [124:0] v;
      v = '0;
      for (int k = 0; k < 25; k++) begin
         v[5*k +: 5] = 5'(k + 1);
      end
      return v;
   endfunction

   task automatic start_board0();
      int n;
      bus0.start = 1'b1;
      step();
      bus0.start = 1'b0;
      n = 0;
      while (!bus0.mark_ready && n < 200) begin
         step();
         n++;
      end
      check_eq("fill_ready", bus0.mark_ready, 1'b1);
   endtask

   task automatic do_mark(input logic [4:0] num, input logic exp_hit, input logic [7:0] exp_disp);
      int         n;
      logic [7:0] prev_disp;
      prev_disp       = bus0.display_nums;
      bus0.mark_valid = 1'b1;
      bus0.mark_num   = num;
      n = 0;
      while (!bus0.mark_ready && n < 100) begin
         step();
         n++;
      end
      step();
      bus0.mark_valid = 1'b0;
      check_eq($sformatf("done_%0d", num), bus0.mark_done, 1'b1);
      check_eq($sformatf("hit_%0d", num), bus0.mark_hit, exp_hit);
      if (exp_hit) begin
         n = 0;
         while (bus0.busy && n < 50) begin
            step();
            n++;
            if (n == 12) check_eq($sformatf("disp_hold_%0d", num), bus0.display_nums, prev_disp);
         end
         check_eq($sformatf("scan_lat_%0d", num), n, 13);
      end else begin
         check_eq($sformatf("miss_idle_%0d", num), bus0.busy, 1'b0);
      end
      check_eq($sformatf("disp_%0d", num), bus0.display_nums, exp_disp);
   endtask

   logic [7:0]   exp_all [25] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                                  8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03,
                                  8'h03, 8'h04, 8'h06, 8'h07, 8'h08, 8'h09, 8'h12};
   logic [124:0] perm_maps [3];
   int           offsets [3] = '{0, 7, 50};

   initial begin
      logic [25:0] seen;
      int          n;
      bus0.start = 0; bus0.mark_valid = 0; bus0.mark_num = 0;
      bus1.start = 0; bus1.mark_valid = 0; bus1.mark_num = 0;
      #3 rst = 1'b1;
      repeat (3) step();

      check_eq("rst_map", bus0.map, 125'd0);
      check_eq("rst_circle", bus0.circle, 25'd0);
      check_eq("rst_disp", bus0.display_nums, 8'h00);
      check_eq("rst_win", bus0.win, 1'b0);
      check_eq("rst_done", bus0.mark_done, 1'b0);
      check_eq("rst_hit", bus0.mark_hit, 1'b0);
      check_eq("rst_busy", bus0.busy, 1'b0);
      check_eq("rst_ready", bus0.mark_ready, 1'b0);
      rst = 1'b0;
      step();

      // Marks are ignored in IDLE
      bus0.mark_valid = 1'b1;
      bus0.mark_num   = 5'd1;
      repeat (3) begin
         step();
         check_eq("idle_done", bus0.mark_done, 1'b0);
         check_eq("idle_ready", bus0.mark_ready, 1'b0);
      end
      bus0.mark_valid = 1'b0;

      start_board0();
      check_eq("ident_map", bus0.map, ident_map());
      check_eq("ident_busy", bus0.busy, 1'b0);
      check_eq("ident_circle", bus0.circle, 25'd0);

      // Row 0
      for (int v = 1; v <= 4; v++) do_mark(5'(v), 1'b1, 8'h00);
      do_mark(5'd5, 1'b1, 8'h01);
      check_eq("row_circle", bus0.circle, 25'h000001F);
      check_eq("row_win", bus0.win, 1'b0);

      // Diagonals
      start_board0();
      check_eq("refill_circle", bus0.circle, 25'd0);
      check_eq("refill_disp", bus0.display_nums, 8'h00);
      do_mark(5'd1, 1'b1, 8'h00);
      do_mark(5'd7, 1'b1, 8'h00);
      do_mark(5'd13, 1'b1, 8'h00);
      do_mark(5'd19, 1'b1, 8'h00);
      do_mark(5'd25, 1'b1, 8'h01);
      do_mark(5'd5, 1'b1, 8'h01);
      do_mark(5'd9, 1'b1, 8'h01);
      do_mark(5'd17, 1'b1, 8'h01);
      do_mark(5'd21, 1'b1, 8'h02);

      // start and mark in the same PLAY cycle: start wins, no mark_done
      bus0.start      = 1'b1;
      bus0.mark_valid = 1'b1;
      bus0.mark_num   = 5'd2;
      step();
      bus0.start      = 1'b0;
      bus0.mark_valid = 1'b0;
      check_eq("start_wins_done", bus0.mark_done, 1'b0);
      check_eq("start_wins_busy", bus0.busy, 1'b1);

      // Full board
      start_board0();
      for (int v = 1; v <= 25; v++) begin
         do_mark(5'(v), 1'b1, exp_all[v-1]);
         if (v == 20) check_eq("win_at4", bus0.win, 1'b0);
         if (v == 21) check_eq("win_at6", bus0.win, 1'b1);
      end
      check_eq("full_win", bus0.win, 1'b1);
      check_eq("full_circle", bus0.circle, 25'h1FFFFFF);
      do_mark(5'd13, 1'b0, 8'h12);
      check_eq("remark_circle", bus0.circle, 25'h1FFFFFF);
      do_mark(5'd0, 1'b0, 8'h12);
      do_mark(5'd26, 1'b0, 8'h12);

      // Shuffled board at different start offsets
      for (int t = 0; t < 3; t++) begin
         repeat (offsets[t]) step();
         bus1.start = 1'b1;
         step();
         bus1.start = 1'b0;
         n = 0;
         while (!bus1.mark_ready && n < 5000) begin
            step();
            n++;
         end
         check_eq($sformatf("shuf_ready_%0d", t), bus1.mark_ready, 1'b1);
         seen = '0;
         for (int k = 0; k < 25; k++) seen[bus1.map[5*k +: 5]] = 1'b1;
         check_eq($sformatf("shuf_perm_%0d", t), seen, 26'h3FFFFFE);
         perm_maps[t] = bus1.map;
      end
      check_eq("shuf_diff01", perm_maps[0] == perm_maps[1], 1'b0);
      check_eq("shuf_diff12", perm_maps[1] == perm_maps[2], 1'b0);
      check_eq("shuf_diff02", perm_maps[0] == perm_maps[2], 1'b0);

      // Reset five cycles into a SCAN that would complete row 0
      start_board0();
      for (int v = 1; v <= 4; v++) do_mark(5'(v), 1'b1, 8'h00);
      bus0.mark_valid = 1'b1;
      bus0.mark_num   = 5'd5;
      step();
      bus0.mark_valid = 1'b0;
      check_eq("pre_rst_hit", bus0.mark_hit, 1'b1);
      repeat (5) step();
      check_eq("pre_rst_busy", bus0.busy, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_map", bus0.map, 125'd0);
      check_eq("mid_rst_circle", bus0.circle, 25'd0);
      check_eq("mid_rst_disp", bus0.display_nums, 8'h00);
      check_eq("mid_rst_win", bus0.win, 1'b0);
      check_eq("mid_rst_busy", bus0.busy, 1'b0);
      step();
      step();
      rst = 1'b0;
      bus0.mark_valid = 1'b1;
      bus0.mark_num   = 5'd3;
      repeat (3) begin
         step();
         check_eq("post_rst_done", bus0.mark_done, 1'b0);
         check_eq("post_rst_ready", bus0.mark_ready, 1'b0);
      end
      bus0.mark_valid = 1'b0;
      repeat (15) step();
      check_eq("post_rst_disp", bus0.display_nums, 8'h00);
      check_eq("post_rst_circle", bus0.circle, 25'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
